// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter and its read-tag pipeline.
package sram_arb_pkg;

  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] REQ_VGA  = 2'd0;
  localparam logic [IDX_W-1:0] REQ_UART = 2'd1;
  localparam logic [IDX_W-1:0] REQ_M1   = 2'd2;
  localparam logic [IDX_W-1:0] REQ_M2   = 2'd3;

  typedef enum logic {S_ARB, S_HOLD} arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, requester} tags for issued reads,
// so that returning SRAM data can be steered to the requester that asked for it.
module sram_rd_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    clr_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  // Clearing drops every read still in flight so it never produces a strobe.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between NUM_REQ requesters: fixed priority for requester 0,
// round-robin among the rest, bounded burst locking and tagged read-data return.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic                      Clock_50,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ-1:0]        we_n_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [ADDR_W-1:0]         SRAM_address_o,
  output logic [DATA_W-1:0]         SRAM_write_data_o,
  output logic                      SRAM_we_n_o,
  input  logic [DATA_W-1:0]         SRAM_read_data_i
);

  localparam int               CNT_W      = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_wdata_q;
  logic              sram_we_n_q;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  logic               owner_active, preempt, hold_keep, hold_max_exit;
  logic [NUM_REQ-1:0] excl_mask, arb_req, gnt;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx, cand, win_idx;
  rd_tag_t            tag_in, tag_out;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata_i[g*DATA_W +: DATA_W];
  end

  // Any HOLD exit falls through to the ARB decision in the same cycle, so the
  // port never idles at a burst boundary; a limit-expired owner sits out once.
  always_comb begin
    owner_active  = 1'b0;
    preempt       = 1'b0;
    hold_keep     = 1'b0;
    hold_max_exit = 1'b0;
    if (state_q == S_HOLD) begin
      owner_active  = req_i[owner_q] & lock_i[owner_q];
      preempt       = req_i[REQ_VGA] && (owner_q != REQ_VGA);
      hold_keep     = owner_active && !preempt && (hold_cnt_q < HOLD_LIMIT);
      hold_max_exit = owner_active && !preempt && (hold_cnt_q == HOLD_LIMIT);
    end

    excl_mask = '0;
    if (hold_max_exit) excl_mask[owner_q] = 1'b1;
    arb_req = req_i & ~excl_mask;
    if (arb_req == '0) arb_req = req_i;

    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    if (arb_req[REQ_VGA]) begin
      arb_valid = 1'b1;
      arb_idx   = REQ_VGA;
    end else begin
      for (int off = 1; off < NUM_REQ; off++) begin
        cand = IDX_W'((int'(rr_ptr_q) - 1 + off) % (NUM_REQ - 1) + 1);
        if (!arb_valid && arb_req[cand]) begin
          arb_valid = 1'b1;
          arb_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gnt        = '0;
    win_idx    = owner_q;
    if (hold_keep) begin
      gnt[owner_q] = 1'b1;
      if (hold_cnt_q < HOLD_LIMIT) hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end else begin
      state_d    = S_ARB;
      hold_cnt_d = '0;
      if (arb_valid) begin
        gnt[arb_idx] = 1'b1;
        win_idx      = arb_idx;
        if (arb_idx != REQ_VGA) rr_ptr_d = arb_idx;
        if (lock_i[arb_idx]) begin
          state_d    = S_HOLD;
          owner_d    = arb_idx;
          hold_cnt_d = CNT_W'(1);
        end
      end
    end
    tag_in.valid = (|gnt) & we_n_i[win_idx];
    tag_in.idx   = win_idx;
  end

  // Arbiter state plus the SRAM pin registers; idle cycles park the port as a read.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q      <= S_ARB;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      hold_cnt_q   <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_we_n_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      if (|gnt) begin
        sram_addr_q  <= addr_arr[win_idx];
        sram_wdata_q <= wdata_arr[win_idx];
        sram_we_n_q  <= we_n_i[win_idx];
      end else begin
        sram_we_n_q <= 1'b1;
      end
    end
  end

  sram_rd_tag_pipe #(.DEPTH(READ_LAT)) u_tag_pipe (
    .clk_i (Clock_50),
    .clr_i (Reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_comb begin
    rvalid_o = '0;
    if (tag_out.valid) rvalid_o[tag_out.idx] = 1'b1;
  end

  assign gnt_o             = gnt;
  assign rdata_o           = SRAM_read_data_i;
  assign SRAM_address_o    = sram_addr_q;
  assign SRAM_write_data_o = sram_wdata_q;
  assign SRAM_we_n_o       = sram_we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, all compared
// against a rule-level arbitration / SRAM reference model.
module tb_sram_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 16;
  localparam int READ_LAT = 2;
  localparam int MAX_HOLD = 64;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req, lock, weN;
  logic [NUM_REQ*ADDR_W-1:0] addrBus;
  logic [NUM_REQ*DATA_W-1:0] wdataBus;
  logic [NUM_REQ-1:0]        gnt, rvalid;
  logic [DATA_W-1:0]         rdata, sramRd;
  logic [ADDR_W-1:0]         sramAddr;
  logic [DATA_W-1:0]         sramWdata;
  logic                      sramWeN;

  sram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ_LAT(READ_LAT), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .Clock_50          (clock),
    .Reset             (reset),
    .req_i             (req),
    .lock_i            (lock),
    .we_n_i            (weN),
    .addr_i            (addrBus),
    .wdata_i           (wdataBus),
    .gnt_o             (gnt),
    .rvalid_o          (rvalid),
    .rdata_o           (rdata),
    .SRAM_address_o    (sramAddr),
    .SRAM_write_data_o (sramWdata),
    .SRAM_we_n_o       (sramWeN),
    .SRAM_read_data_i  (sramRd)
  );

  always #10 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [ADDR_W-1:0]  tbAddr  [NUM_REQ];
  logic [DATA_W-1:0]  tbWdata [NUM_REQ];
  logic [NUM_REQ-1:0] tbReq  = '0;
  logic [NUM_REQ-1:0] tbWeN  = '1;

  logic [DATA_W-1:0] sramMem [int];
  logic [DATA_W-1:0] refMem  [int];

  int                 mOwner = -1;
  int                 mRun   = 0;
  int                 mRr    = NUM_REQ - 1;
  logic [ADDR_W-1:0]  mAddr  = '0;
  logic [DATA_W-1:0]  mWdata = '0;
  logic               mWeN   = 1'b1;
  logic [NUM_REQ-1:0] expRvMask [int];
  logic [DATA_W-1:0]  expRvData [int];

  logic [NUM_REQ-1:0] obsGnt = '0, obsRvalid;
  logic [ADDR_W-1:0]  obsAddr;
  logic [DATA_W-1:0]  obsWdata, obsRdata;
  logic               obsWeN;

  function automatic logic [DATA_W-1:0] defVal(input int a);
    return DATA_W'(a) ^ 16'hA5C3;
  endfunction

  // Simple SRAM: one cycle from address pins to read data.
  always @(posedge clock) begin
    if (sramWeN === 1'b0) sramMem[int'(sramAddr)] = sramWdata;
    sramRd <= sramMem.exists(int'(sramAddr)) ? sramMem[int'(sramAddr)] : defVal(int'(sramAddr));
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict by the arbitration rules, compare, advance.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                               input logic [NUM_REQ-1:0] w, input logic rst);
    int winner, excl;
    logic active, pre;
    logic [NUM_REQ-1:0] eff, tmp, expGnt, expMask;
    @(negedge clock);
    req = r; lock = l; weN = w; reset = rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      addrBus[i*ADDR_W +: ADDR_W]  = tbAddr[i];
      wdataBus[i*DATA_W +: DATA_W] = tbWdata[i];
    end
    tbReq = r;
    #1;
    winner = -1;
    excl   = -1;
    if (mOwner >= 0) begin
      active = r[mOwner] && l[mOwner];
      pre    = r[0] && (mOwner != 0);
      if (active && !pre && mRun < MAX_HOLD) begin
        winner = mOwner;
        mRun++;
      end else begin
        if (active && !pre) excl = mOwner;
        mOwner = -1;
        mRun   = 0;
      end
    end
    if (winner < 0) begin
      eff = r;
      if (excl >= 0) begin
        tmp = r;
        tmp[excl] = 1'b0;
        if (tmp != '0) eff = tmp;
      end
      if (eff[0]) winner = 0;
      else begin
        for (int s = 1; s < NUM_REQ; s++) begin
          int c;
          c = (mRr - 1 + s) % (NUM_REQ - 1) + 1;
          if (winner < 0 && eff[c]) winner = c;
        end
      end
      if (winner > 0) mRr = winner;
      if (winner >= 0 && l[winner]) begin
        mOwner = winner;
        mRun   = 1;
      end
    end
    expGnt = '0;
    if (winner >= 0) expGnt[winner] = 1'b1;
    expMask = expRvMask.exists(cyc) ? expRvMask[cyc] : '0;

    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    checkOutput("sram_addr", 32'(sramAddr), 32'(mAddr));
    checkOutput("sram_wdata", 32'(sramWdata), 32'(mWdata));
    checkOutput("sram_we_n", 32'(sramWeN), 32'(mWeN));
    checkOutput("rvalid", 32'(rvalid), 32'(expMask));
    if (expMask != '0) checkOutput("rdata", 32'(rdata), 32'(expRvData[cyc]));

    obsGnt = gnt; obsRvalid = rvalid; obsAddr = sramAddr;
    obsWdata = sramWdata; obsWeN = sramWeN; obsRdata = rdata;

    if (winner >= 0) begin
      mAddr  = tbAddr[winner];
      mWdata = tbWdata[winner];
      mWeN   = w[winner];
      if (w[winner]) begin
        expRvMask[cyc + READ_LAT] = expGnt;
        expRvData[cyc + READ_LAT] = refMem.exists(int'(mAddr)) ? refMem[int'(mAddr)] : defVal(int'(mAddr));
      end else begin
        refMem[int'(mAddr)] = mWdata;
      end
    end else begin
      mWeN = 1'b1;
    end
    if (rst) begin
      mAddr = '0; mWdata = '0; mWeN = 1'b1;
      mOwner = -1; mRun = 0; mRr = NUM_REQ - 1;
      expRvMask.delete();
      expRvData.delete();
    end
    cyc++;
  endtask

  task automatic randomizeFields();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!(tbReq[i] && !obsGnt[i])) begin
        tbAddr[i]  = ADDR_W'($urandom_range(0, 15));
        tbWdata[i] = DATA_W'($urandom);
        tbWeN[i]   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    int run2, ones;
    logic seen;
    logic [NUM_REQ-1:0] g64, g65, g10, rv2, rv3;
    logic [ADDR_W-1:0]  a10, a11;
    logic [DATA_W-1:0]  d2;

    for (int i = 0; i < NUM_REQ; i++) begin
      tbAddr[i]  = ADDR_W'(i * 16 + 5);
      tbWdata[i] = DATA_W'(16'h1000 + i);
    end
    sramMem[int'(18'h23E00)] = 16'hBEEF;
    refMem[int'(18'h23E00)]  = 16'hBEEF;
    req = '0; lock = '0; weN = '1; addrBus = '0; wdataBus = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Reset state
    applyStimulus('0, '0, '1, 1'b0);
    checkOutput("rst_gnt", 32'(obsGnt), 32'h0);
    checkOutput("rst_rvalid", 32'(obsRvalid), 32'h0);
    checkOutput("rst_we_n", 32'(obsWeN), 32'h1);
    checkOutput("rst_addr", 32'(obsAddr), 32'h0);
    checkOutput("rst_wdata", 32'(obsWdata), 32'h0);

    // Round-robin alternation between requesters 1 and 2
    for (int n = 0; n < 6; n++) begin
      applyStimulus(4'b0110, 4'b0000, 4'b1111, 1'b0);
      checkOutput("rr_alt", 32'(obsGnt), (n % 2 == 0) ? 32'h2 : 32'h4);
      checkOutput("rr_we_n", 32'(obsWeN), 32'h1);
    end

    // Lock limit: 64 grants to 2, one to 1, then 2 again
    applyStimulus('0, '0, '1, 1'b1);
    run2 = 0; ones = 0; seen = 1'b0; g64 = '0; g65 = '0;
    for (int n = 0; n < 100; n++) begin
      applyStimulus((n == 0) ? 4'b0100 : 4'b0110, 4'b0100, 4'b1111, 1'b0);
      if (n == 64) g64 = obsGnt;
      if (n == 65) g65 = obsGnt;
      if (obsGnt == 4'b0010) ones++;
      if (!seen && obsGnt == 4'b0100) run2++;
      else seen = 1'b1;
    end
    checkOutput("lock_run", 32'(run2), 32'd64);
    checkOutput("lock_gnt64", 32'(g64), 32'h2);
    checkOutput("lock_gnt65", 32'(g65), 32'h4);
    checkOutput("lock_ones", 32'(ones), 32'd1);

    // Preemption of a locked requester 3 by requester 0
    applyStimulus('0, '0, '1, 1'b1);
    tbAddr[3] = 18'h30003;
    tbAddr[0] = 18'h00A00;
    for (int n = 0; n < 10; n++) applyStimulus(4'b1000, 4'b1000, 4'b1111, 1'b0);
    applyStimulus(4'b1001, 4'b1000, 4'b1111, 1'b0);
    g10 = obsGnt; a10 = obsAddr;
    applyStimulus(4'b1000, 4'b1000, 4'b1111, 1'b0);
    a11 = obsAddr;
    checkOutput("pre_gnt10", 32'(g10), 32'h1);
    checkOutput("pre_addr10", 32'(a10), 32'h30003);
    checkOutput("pre_addr11", 32'(a11), 32'h00A00);

    // Read return then a write that must not strobe rvalid
    applyStimulus('0, '0, '1, 1'b1);
    tbAddr[1] = 18'h23E00;
    applyStimulus(4'b0010, 4'b0000, 4'b1111, 1'b0);
    tbAddr[2] = 18'h00100;
    tbWdata[2] = 16'h1234;
    applyStimulus(4'b0100, 4'b0000, 4'b1011, 1'b0);
    applyStimulus('0, '0, '1, 1'b0);
    rv2 = obsRvalid; d2 = obsRdata;
    applyStimulus('0, '0, '1, 1'b0);
    rv3 = obsRvalid;
    checkOutput("rd_rvalid", 32'(rv2), 32'h2);
    checkOutput("rd_rdata", 32'(d2), 32'hBEEF);
    checkOutput("wr_no_rvalid", 32'(rv3), 32'h0);

    // Idle: no grant, port parked as read, address held
    for (int n = 0; n < 3; n++) begin
      applyStimulus('0, '0, '1, 1'b0);
      checkOutput("idle_gnt", 32'(obsGnt), 32'h0);
      checkOutput("idle_we_n", 32'(obsWeN), 32'h1);
      checkOutput("idle_addr", 32'(obsAddr), 32'h00100);
    end

    // Reset one cycle after a read grant kills the pending return
    tbAddr[1] = 18'h11111;
    applyStimulus(4'b0010, 4'b0000, 4'b1111, 1'b0);
    applyStimulus('0, '0, '1, 1'b1);
    applyStimulus('0, '0, '1, 1'b0);
    checkOutput("rstmid_rvalid", 32'(obsRvalid), 32'h0);
    checkOutput("rstmid_addr", 32'(obsAddr), 32'h0);
    checkOutput("rstmid_we_n", 32'(obsWeN), 32'h1);
    checkOutput("rstmid_wdata", 32'(obsWdata), 32'h0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus('0, '0, '1, 1'b0);
      checkOutput("rstmid_late_rvalid", 32'(obsRvalid), 32'h0);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      logic [NUM_REQ-1:0] r, l;
      logic rst;
      randomizeFields();
      r    = NUM_REQ'($urandom);
      r[0] = ($urandom_range(0, 7) == 0);
      l    = NUM_REQ'($urandom) | NUM_REQ'($urandom);
      rst  = ($urandom_range(0, 149) == 0);
      if (rst) r = '0;
      applyStimulus(r, l, tbWeN, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
